score_display_bcd: RTL and testbench

- Per-player score keeper and renderer for the pong VGA path.
- Holds a multi-digit BCD score, updated by single-cycle point pulses, and draws it as seven-segment digits at a parametrised screen position.
- Blinks the score for a set number of frames after each point and flags a win.
- Instantiated once per player; the mono pixel output is ORed into the frame mux alongside paddles and ball.

---
 rtl/score_display_bcd.sv | 185 ++++++++++++++++++
 tb/tb_score_display_bcd.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/score_display_bcd.sv
// Per-player BCD score keeper with seven-segment renderer, post-point blink and win flag.
// The mono pixel output is meant to be ORed into the frame mux.
module score_display_digit #(
    parameter int CX    = 570,
    parameter int Y0    = 20,
    parameter int SEG_L = 40,
    parameter int SEG_T = 10,
    parameter int SEG_V = 30
) (
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic       lit
);
    localparam logic [9:0] XA0 = 10'(CX);
    localparam logic [9:0] XA1 = 10'(CX + SEG_L);
    localparam logic [9:0] XL1 = 10'(CX + SEG_T);
    localparam logic [9:0] XR0 = 10'(CX + SEG_L - SEG_T);
    localparam logic [9:0] YA0 = 10'(Y0);
    localparam logic [9:0] YA1 = 10'(Y0 + SEG_T);
    localparam logic [9:0] YG0 = 10'(Y0 + SEG_V);
    localparam logic [9:0] YG1 = 10'(Y0 + SEG_V + SEG_T);
    localparam logic [9:0] YD0 = 10'(Y0 + 2*SEG_V);
    localparam logic [9:0] YD1 = 10'(Y0 + 2*SEG_V + SEG_T);

    logic xf, xl, xr, ya, yg, yd, yu, yl;
    logic [6:0] hit, seg;  // {a,b,c,d,e,f,g}

    assign xf = (h_count >= XA0) && (h_count < XA1);
    assign xl = (h_count >= XA0) && (h_count < XL1);
    assign xr = (h_count >= XR0) && (h_count < XA1);
    assign ya = (v_count >= YA0) && (v_count < YA1);
    assign yg = (v_count >= YG0) && (v_count < YG1);
    assign yd = (v_count >= YD0) && (v_count < YD1);
    assign yu = (v_count >= YA0) && (v_count < YG1);
    assign yl = (v_count >= YG0) && (v_count < YD1);

    assign hit = {xf & ya, xr & yu, xr & yl, xf & yd, xl & yl, xl & yu, xf & yg};

    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

    assign lit = !blank && |(seg & hit);
endmodule

module score_display_bcd #(
    parameter int DIGITS       = 2,
    parameter int WIN_SCORE    = 11,
    parameter int X0           = 570,
    parameter int Y0           = 20,
    parameter int SEG_L        = 40,
    parameter int SEG_T        = 10,
    parameter int SEG_V        = 30,
    parameter int PITCH        = 50,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_HALF   = 8,
    parameter int LZ_BLANK     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  point,
    input  logic                  frame_tick,
    input  logic [9:0]            h_count,
    input  logic [9:0]            v_count,
    output logic                  pixel_on,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  win,
    output logic                  blinking
);
    localparam int CW = $clog2(BLINK_FRAMES);
    localparam int HB = $clog2(BLINK_HALF);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    typedef enum logic {IDLE, BLINK} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DIGITS-1:0][3:0] score, score_inc;
    logic [DIGITS-1:0]      lit, blank;
    logic                   accept, hidden;

    assign score_bcd = score;
    assign win       = (score == WIN_BCD);
    assign blinking  = (state == BLINK);
    assign accept    = point && !win;
    assign hidden    = (state == BLINK) && cnt[HB];

    // BCD increment: a digit rolls 9->0 and passes the carry up.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        score_inc = score;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score[i] == 4'd9) begin
                    score_inc[i] = 4'd0;
                end else begin
                    score_inc[i] = score[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (clear) begin
            score <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            score <= score_inc;
            state <= BLINK;
            cnt   <= '0;
        end else if (state == BLINK && frame_tick) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(BLINK_FRAMES - 2))
                state <= IDLE;
        end
    end

    // Digit k=0 is the most significant; blank it while it and everything above are zero.
    always_comb begin
        logic zp;
        zp    = 1'b1;
        blank = '0;
        for (int k = 0; k < DIGITS; k++) begin
            zp       = zp && (score[DIGITS-1-k] == 4'd0);
            blank[k] = (LZ_BLANK != 0) && (k < DIGITS-1) && zp;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        score_display_digit #(
            .CX    (X0 + k*PITCH),
            .Y0    (Y0),
            .SEG_L (SEG_L),
            .SEG_T (SEG_T),
            .SEG_V (SEG_V)
        ) u_digit (
            .h_count (h_count),
            .v_count (v_count),
            .nibble  (score[DIGITS-1-k]),
            .blank   (blank[k]),
            .lit     (lit[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixel_on <= 1'b0;
        else        pixel_on <= (|lit) && !hidden;
    end
endmodule

// File: tb/tb_score_display_bcd.sv
// Directed bench for score_display_bcd with default parameters.
module tb_score_display_bcd;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       point = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic       pixel_on;
    logic [7:0] score_bcd;
    logic       win;
    logic       blinking;

    int n_vec = 0;
    int n_err = 0;

    score_display_bcd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .point      (point),
        .frame_tick (frame_tick),
        .h_count    (h_count),
        .v_count    (v_count),
        .pixel_on   (pixel_on),
        .score_bcd  (score_bcd),
        .win        (win),
        .blinking   (blinking)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic p, input logic f, input logic c);
        @(negedge clk);
        point = p; frame_tick = f; clear = c;
        @(negedge clk);
        point = 1'b0; frame_tick = 1'b0; clear = 1'b0;
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic pix(input int x, input int y);
        @(negedge clk);
        h_count = 10'(x); v_count = 10'(y);
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_score", 32'(score_bcd), 32'h00);
        check("rst_win", 32'(win), 0);
        check("rst_blink", 32'(blinking), 0);
        check("rst_pix", 32'(pixel_on), 0);
        @(negedge clk);
        rst_n = 1'b1;

        points(9);
        check("score_09", 32'(score_bcd), 32'h09);
        check("win_09", 32'(win), 0);
        points(1);
        check("score_10", 32'(score_bcd), 32'h10);
        check("win_10", 32'(win), 0);
        points(1);
        check("score_11", 32'(score_bcd), 32'h11);
        check("win_11", 32'(win), 1);
        check("blink_11", 32'(blinking), 1);
        // A point after the win must not restart the blink window.
        ticks(20);
        points(1);
        check("score_held", 32'(score_bcd), 32'h11);
        ticks(11);
        check("no_restart", 32'(blinking), 0);

        pulse(1'b0, 1'b0, 1'b1);
        check("clr_score", 32'(score_bcd), 32'h00);
        check("clr_win", 32'(win), 0);
        points(5);
        check("score_05", 32'(score_bcd), 32'h05);
        pix(575, 22);
        check("lz_blank", 32'(pixel_on), 0);
        pix(625, 22);
        check("lsd_seg_a", 32'(pixel_on), 1);
        pix(655, 35);
        check("five_no_b", 32'(pixel_on), 0);
        pix(0, 0);
        check("background", 32'(pixel_on), 0);

        // Blink pattern on a lit segment of the LSD.
        pix(625, 22);
        points(1);
        check("score_06", 32'(score_bcd), 32'h06);
        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            check($sformatf("blink_pix_%0d", i), 32'(pixel_on), ((i >> 3) & 1) == 0 ? 1 : 0);
            check($sformatf("blinking_%0d", i), 32'(blinking), 1);
            ticks(1);
            @(negedge clk);
        end
        check("blink_end", 32'(blinking), 0);
        check("blink_end_pix", 32'(pixel_on), 1);

        points(1);
        ticks(9);
        @(negedge clk);
        check("hidden_9", 32'(pixel_on), 0);
        pulse(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("pt_tick_score", 32'(score_bcd), 32'h08);
        check("pt_tick_blink", 32'(blinking), 1);
        check("pt_tick_pix", 32'(pixel_on), 1);

        pulse(1'b0, 1'b0, 1'b1);
        points(7);
        check("score_07", 32'(score_bcd), 32'h07);
        pulse(1'b1, 1'b0, 1'b1);
        check("pt_clr_score", 32'(score_bcd), 32'h00);
        check("pt_clr_blink", 32'(blinking), 0);

        points(3);
        ticks(2);
        @(negedge clk);
        check("pre_rst_score", 32'(score_bcd), 32'h03);
        check("pre_rst_pix", 32'(pixel_on), 1);
        check("pre_rst_blink", 32'(blinking), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_score", 32'(score_bcd), 32'h00);
        check("arst_blink", 32'(blinking), 0);
        check("arst_pix", 32'(pixel_on), 0);
        check("arst_win", 32'(win), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
